riscv_dmem_rsp: RTL and testbench
=================================

# riscv_dmem_rsp

Data-memory response stage directly downstream of the load/store unit. Records the metadata of every access the LSU issues to the BIU (size, low address bits, signedness, direction). On each `dmem_ack_i` it pops the oldest record, extracts and aligns the addressed bytes from `dmem_q_i`, and applies sign or zero extension. It delivers a registered, write-back-ready result plus fault flags to the WB stage, and back-pressures the LSU when its outstanding-access queue is full.

## Interface
- `XLEN`, 32, data width; 32 or 64.
- `DEPTH`, 2, maximum number of outstanding accesses; power of two, ≥2.

- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in 1: LSU issues an access this cycle (mirrors LSU `dmem_req_o`).
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_size_i` in biu_size_t: BYTE/HWORD/WORD/DWORD/UNDEF_SIZE.
- `req_adr_i` in 3: address bits [2:0]; bit 2 is ignored when XLEN=32.
- `req_unsigned_i` in 1: zero-extend (LBU/LHU/LWU).
- `flush_i` in 1: kill all records currently in the queue.
- `st_be_i` in 1: big-endian data mode.
- `dmem_ack_i` in 1: BIU completes the oldest access.
- `dmem_q_i` in XLEN: BIU read data, naturally aligned bus word.
- `dmem_misaligned_i`, `dmem_page_fault_i` in 1: fault flags, qualified by ack.
- `full_o` out 1: queue full; the LSU must stall (combinational from count).
- `pending_o` out $clog2(DEPTH+1): number of outstanding records.
- `rsp_valid_o` out 1: registered response valid, one-cycle pulse.
- `rsp_load_o` out 1: response belongs to a load (write-back required).
- `rsp_q_o` out XLEN: aligned and extended load data; 0 for stores and faults.
- `rsp_misaligned_o`, `rsp_page_fault_o` out 1: faults for this response.
- `err_o` out 1: sticky protocol error.

## Operation
- Queue: circular FIFO of DEPTH records {we, size, adr[2:0], unsigned, killed}, with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count.
- Push on `req_i`. Pop on `dmem_ack_i`.
- Simultaneous push and pop is legal in any state, including full and empty+1. The count is unchanged.
- Push while full without a pop: the request is dropped and `err_o` is set.
- Ack while empty: ignored, with no response; `err_o` is set.
- `flush_i`: sets `killed` on every resident record. A request pushed in the same cycle is not killed. A popped killed record produces no `rsp_valid_o`. Count and pointers are untouched, because the BIU still acks those accesses.
- Extraction, with off = adr[1:0] (XLEN=32) or adr[2:0] (XLEN=64):
  - raw = `dmem_q_i` >> (8·off).
  - BYTE → raw[7:0].
  - HWORD → raw[15:0].
  - WORD → raw[31:0].
  - DWORD → full word; legal only when XLEN=64, otherwise treated as UNDEF_SIZE.
- Big-endian (`st_be_i`=1): reverse the byte order of the extracted HWORD, WORD or DWORD field before extension. BYTE is unaffected.
- Extension to XLEN: sign-extend from the field MSB unless `unsigned`; zero-extend when set. WORD unsigned with XLEN=32 is identical to signed.
- UNDEF_SIZE → `rsp_q_o`=0.
- Stores: `rsp_valid_o`=1, `rsp_load_o`=0, `rsp_q_o`=0, fault flags passed through.
- Fault on ack (either flag): `rsp_q_o`=0, flags copied, `rsp_load_o` as recorded.

## Timing
- `rsp_*` outputs are registered: ack in cycle N → `rsp_valid_o`=1 in cycle N+1 for exactly one cycle, unless a new ack arrives in cycle N+1.
- Back-to-back acks give back-to-back responses. Throughput is one response per cycle.
- `full_o` = (count==DEPTH), a combinational function of registered count. A record pushed in cycle N is poppable by an ack in cycle N+1 at the earliest.
- An ack in the same cycle as the push of the only record counts as ack while empty (error).
- Reset values (rst_i=1, synchronous): pointers 0, count 0, `full_o`=0, `pending_o`=0, `rsp_valid_o`=0, `rsp_load_o`=0, `rsp_q_o`=0, fault flags 0, `err_o`=0.
- Reset mid-operation discards all records. Acks arriving in the cycle reset is asserted are ignored.
- `err_o` clears only on reset.

## Test plan
- XLEN=32, LB at adr=3, q=0x80_11_22_33 → `rsp_q_o`=0xFFFF_FF80; same access with LBU → 0x0000_0080.
- LH at adr=2, q=0xBEEF_1234, `st_be_i`=1 → field 0xBEEF swapped to 0xEFBE → `rsp_q_o`=0xFFFF_EFBE; with `st_be_i`=0 → 0xFFFF_BEEF.
- DEPTH=2: two reqs without ack → `full_o`=1, `pending_o`=2. A third req with a simultaneous ack → accepted, `pending_o` stays 2, `err_o`=0. A third req with no ack → `err_o`=1.
- Two loads queued, `flush_i` pulsed, one new store pushed, three acks → only the store produces `rsp_valid_o` (`rsp_load_o`=0); `pending_o` returns to 0.
- LW ack with `dmem_page_fault_i`=1, q=0x1234_5678 → next cycle `rsp_valid_o`=1, `rsp_q_o`=0, `rsp_page_fault_o`=1, `rsp_load_o`=1.
- `rst_i` asserted with 2 pending, then an ack after reset → ignored, `err_o`=1, `rsp_valid_o` stays 0. XLEN=64 LWU at adr=4, q=0xFFFF_FFFF_0000_0000 → 0x0000_0000_FFFF_FFFF.

Source files
------------

// File: rtl/riscv_dmem_rsp.sv
// Data-memory response stage: queues LSU access metadata, then aligns and
// extends BIU read data on each ack into a registered write-back response.
module riscv_dmem_rsp #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_i,
  input  logic                         req_we_i,
  input  logic [2:0]                   req_size_i,
  input  logic [2:0]                   req_adr_i,
  input  logic                         req_unsigned_i,
  input  logic                         flush_i,
  input  logic                         st_be_i,
  input  logic                         dmem_ack_i,
  input  logic [XLEN-1:0]              dmem_q_i,
  input  logic                         dmem_misaligned_i,
  input  logic                         dmem_page_fault_i,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   pending_o,
  output logic                         rsp_valid_o,
  output logic                         rsp_load_o,
  output logic [XLEN-1:0]              rsp_q_o,
  output logic                         rsp_misaligned_o,
  output logic                         rsp_page_fault_o,
  output logic                         err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // biu_size_t encoding
  localparam logic [2:0] SZ_BYTE  = 3'd1;
  localparam logic [2:0] SZ_HWORD = 3'd2;
  localparam logic [2:0] SZ_WORD  = 3'd3;
  localparam logic [2:0] SZ_DWORD = 3'd4;

  function automatic logic [15:0] bswap16(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [XLEN-1:0] bswap_xlen(input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = d;
    for (int i = 0; i < XLEN/8; i++) r[8*i +: 8] = d[XLEN-8-8*i +: 8];
    return r;
  endfunction

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic       q_we     [DEPTH];
  logic [2:0] q_size   [DEPTH];
  logic [2:0] q_adr    [DEPTH];
  logic       q_uns    [DEPTH];
  logic       q_killed [DEPTH];

  logic empty, pop, push;
  logic rd_we, rd_uns, rd_killed;
  logic [2:0] rd_size, rd_adr;

  assign full_o    = (count == CW'(DEPTH));
  assign empty     = (count == {CW{1'b0}});
  assign pending_o = count;
  // An ack can only retire a record pushed in an earlier cycle.
  assign pop       = dmem_ack_i & ~empty;
  assign push      = req_i & (~full_o | pop);

  assign rd_we     = q_we[rd_ptr];
  assign rd_size   = q_size[rd_ptr];
  assign rd_adr    = q_adr[rd_ptr];
  assign rd_uns    = q_uns[rd_ptr];
  assign rd_killed = q_killed[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      err_o <= err_o | (req_i & full_o & ~pop) | (dmem_ack_i & empty);
    end
  end

  // Flush marks resident records; the BIU still acks them, so they stay queued.
  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) q_killed[i] <= 1'b1;
    end
    if (push) begin
      q_we[wr_ptr]     <= req_we_i;
      q_size[wr_ptr]   <= req_size_i;
      q_adr[wr_ptr]    <= req_adr_i;
      q_uns[wr_ptr]    <= req_unsigned_i;
      q_killed[wr_ptr] <= 1'b0;
    end
  end

  logic [2:0]      off;
  logic [XLEN-1:0] raw, fxl, ext;
  logic [15:0]     f16;
  logic [31:0]     f32;

  always_comb begin
    if (XLEN == 64) off = rd_adr;
    else            off = {1'b0, rd_adr[1:0]};
    raw = dmem_q_i >> {off, 3'b000};
    f16 = st_be_i ? bswap16(raw[15:0]) : raw[15:0];
    f32 = st_be_i ? bswap32(raw[31:0]) : raw[31:0];
    fxl = st_be_i ? bswap_xlen(raw) : raw;
    ext = {XLEN{1'b0}};
    case (rd_size)
      SZ_BYTE:  ext = rd_uns ? XLEN'(raw[7:0]) : XLEN'($signed(raw[7:0]));
      SZ_HWORD: ext = rd_uns ? XLEN'(f16) : XLEN'($signed(f16));
      SZ_WORD:  ext = rd_uns ? XLEN'(f32) : XLEN'($signed(f32));
      SZ_DWORD: begin
        if (XLEN == 64) ext = fxl;
        else            ext = {XLEN{1'b0}};
      end
      default:  ext = {XLEN{1'b0}};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o      <= 1'b0;
      rsp_load_o       <= 1'b0;
      rsp_q_o          <= {XLEN{1'b0}};
      rsp_misaligned_o <= 1'b0;
      rsp_page_fault_o <= 1'b0;
    end else if (pop & ~rd_killed) begin
      rsp_valid_o      <= 1'b1;
      rsp_load_o       <= ~rd_we;
      rsp_q_o          <= (rd_we | dmem_misaligned_i | dmem_page_fault_i) ? {XLEN{1'b0}} : ext;
      rsp_misaligned_o <= dmem_misaligned_i;
      rsp_page_fault_o <= dmem_page_fault_i;
    end else begin
      rsp_valid_o      <= 1'b0;
      rsp_load_o       <= 1'b0;
      rsp_q_o          <= {XLEN{1'b0}};
      rsp_misaligned_o <= 1'b0;
      rsp_page_fault_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_rsp.sv
// Scoreboard bench for riscv_dmem_rsp: XLEN=32/DEPTH=2 main instance plus an
// XLEN=64 instance for doubleword and upper-lane extraction.
module tb_riscv_dmem_rsp;

  localparam logic [2:0] SZ_UNDEF = 3'd0;
  localparam logic [2:0] SZ_BYTE  = 3'd1;
  localparam logic [2:0] SZ_HWORD = 3'd2;
  localparam logic [2:0] SZ_WORD  = 3'd3;
  localparam logic [2:0] SZ_DWORD = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req, we, uns, flush, be, ack, mis, pf;
  logic [2:0]  size, adr;
  logic [31:0] dq;
  logic        full, rsp_valid, rsp_load, rsp_mis, rsp_pf, err;
  logic [1:0]  pending;
  logic [31:0] rsp_q;

  logic        req64, we64, uns64, be64, ack64;
  logic [2:0]  size64, adr64;
  logic [63:0] dq64;
  logic        full64, rsp_valid64, rsp_load64, rsp_mis64, rsp_pf64, err64;
  logic [1:0]  pending64;
  logic [63:0] rsp_q64;

  riscv_dmem_rsp #(.XLEN(32), .DEPTH(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .req_we_i(we), .req_size_i(size),
    .req_adr_i(adr), .req_unsigned_i(uns), .flush_i(flush), .st_be_i(be),
    .dmem_ack_i(ack), .dmem_q_i(dq), .dmem_misaligned_i(mis), .dmem_page_fault_i(pf),
    .full_o(full), .pending_o(pending), .rsp_valid_o(rsp_valid), .rsp_load_o(rsp_load),
    .rsp_q_o(rsp_q), .rsp_misaligned_o(rsp_mis), .rsp_page_fault_o(rsp_pf), .err_o(err)
  );

  riscv_dmem_rsp #(.XLEN(64), .DEPTH(2)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .req_i(req64), .req_we_i(we64), .req_size_i(size64),
    .req_adr_i(adr64), .req_unsigned_i(uns64), .flush_i(1'b0), .st_be_i(be64),
    .dmem_ack_i(ack64), .dmem_q_i(dq64), .dmem_misaligned_i(1'b0), .dmem_page_fault_i(1'b0),
    .full_o(full64), .pending_o(pending64), .rsp_valid_o(rsp_valid64), .rsp_load_o(rsp_load64),
    .rsp_q_o(rsp_q64), .rsp_misaligned_o(rsp_mis64), .rsp_page_fault_o(rsp_pf64), .err_o(err64)
  );

  typedef struct {
    logic        load;
    logic [63:0] q;
    logic        mis;
    logic        pf;
  } rsp_t;

  rsp_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, compare any due response, then drop one-shot inputs.
  task automatic tick();
    rsp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_load",  64'(rsp_load),  64'(e.load));
      check("rsp_q",     64'(rsp_q),     e.q);
      check("rsp_mis",   64'(rsp_mis),   64'(e.mis));
      check("rsp_pf",    64'(rsp_pf),    64'(e.pf));
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'd0);
    end
    req = 1'b0; ack = 1'b0; flush = 1'b0; mis = 1'b0; pf = 1'b0;
  endtask

  task automatic load_req(input logic [2:0] s, input logic [2:0] a, input logic u);
    req = 1'b1; we = 1'b0; size = s; adr = a; uns = u;
  endtask

  task automatic store_req(input logic [2:0] s, input logic [2:0] a);
    req = 1'b1; we = 1'b1; size = s; adr = a; uns = 1'b0;
  endtask

  task automatic ack_rsp(input logic [31:0] q, input logic m, input logic p,
                         input logic expect_rsp, input logic eload, input logic [31:0] eq);
    rsp_t e;
    ack = 1'b1; dq = q; mis = m; pf = p;
    if (expect_rsp) begin
      e.load = eload; e.q = 64'(eq); e.mis = m; e.pf = p;
      exp_q.push_back(e);
    end
  endtask

  task automatic single_load(input string tag, input logic [2:0] s, input logic [2:0] a,
                             input logic u, input logic b, input logic [31:0] q,
                             input logic [31:0] eq);
    load_req(s, a, u);
    tick();
    be = b;
    ack_rsp(q, 1'b0, 1'b0, 1'b1, 1'b1, eq);
    tick();
    check({tag, "_pending"}, 64'(pending), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic single64(input string tag, input logic [2:0] s, input logic [2:0] a,
                          input logic u, input logic b, input logic [63:0] q,
                          input logic [63:0] eq);
    req64 = 1'b1; we64 = 1'b0; size64 = s; adr64 = a; uns64 = u;
    @(posedge clk); #1;
    req64 = 1'b0; be64 = b; ack64 = 1'b1; dq64 = q;
    @(posedge clk); #1;
    ack64 = 1'b0;
    check({tag, "_valid"}, 64'(rsp_valid64), 64'd1);
    check({tag, "_q"}, rsp_q64, eq);
  endtask

  initial begin
    req = 1'b0; we = 1'b0; uns = 1'b0; flush = 1'b0; be = 1'b0; ack = 1'b0;
    mis = 1'b0; pf = 1'b0; size = SZ_UNDEF; adr = 3'd0; dq = 32'd0;
    req64 = 1'b0; we64 = 1'b0; uns64 = 1'b0; be64 = 1'b0; ack64 = 1'b0;
    size64 = SZ_UNDEF; adr64 = 3'd0; dq64 = 64'd0;

    // Reset state, with an ack pending during reset that must be ignored
    rst = 1'b1;
    ack = 1'b1;
    tick();
    tick();
    check("rst_full",    64'(full),      64'd0);
    check("rst_pending", 64'(pending),   64'd0);
    check("rst_load",    64'(rsp_load),  64'd0);
    check("rst_q",       64'(rsp_q),     64'd0);
    check("rst_err",     64'(err),       64'd0);
    check("rst_pf",      64'(rsp_pf),    64'd0);
    rst = 1'b0;

    // Extraction and extension
    single_load("lb",   SZ_BYTE,  3'd3, 1'b0, 1'b0, 32'h8011_2233, 32'hFFFF_FF80);
    single_load("lbu",  SZ_BYTE,  3'd3, 1'b1, 1'b0, 32'h8011_2233, 32'h0000_0080);
    single_load("lh_be",SZ_HWORD, 3'd2, 1'b0, 1'b1, 32'hBEEF_1234, 32'hFFFF_EFBE);
    single_load("lh",   SZ_HWORD, 3'd2, 1'b0, 1'b0, 32'hBEEF_1234, 32'hFFFF_BEEF);
    single_load("lhu",  SZ_HWORD, 3'd0, 1'b1, 1'b0, 32'h0000_8001, 32'h0000_8001);
    single_load("lb1",  SZ_BYTE,  3'd1, 1'b0, 1'b0, 32'h0000_7F00, 32'h0000_007F);
    single_load("lw",   SZ_WORD,  3'd0, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678);
    single_load("lw_be",SZ_WORD,  3'd0, 1'b0, 1'b1, 32'h1234_5678, 32'h7856_3412);
    single_load("ld32", SZ_DWORD, 3'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000);
    single_load("undef",SZ_UNDEF, 3'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000);
    be = 1'b0;

    // Faults and stores
    load_req(SZ_WORD, 3'd0, 1'b0);
    tick();
    ack_rsp(32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    store_req(SZ_WORD, 3'd0);
    tick();
    ack_rsp(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("pre_full_err", 64'(err), 64'd0);

    // Fill to DEPTH, push with simultaneous pop, then overflow
    load_req(SZ_WORD, 3'd0, 1'b0);
    tick();
    load_req(SZ_WORD, 3'd0, 1'b0);
    tick();
    check("full_flag",    64'(full),    64'd1);
    check("full_pending", 64'(pending), 64'd2);
    load_req(SZ_WORD, 3'd0, 1'b0);
    ack_rsp(32'hAAAA_5555, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA_5555);
    tick();
    check("pushpop_pending", 64'(pending), 64'd2);
    check("pushpop_err",     64'(err),     64'd0);
    load_req(SZ_BYTE, 3'd0, 1'b0);
    tick();
    check("overflow_err",     64'(err),     64'd1);
    check("overflow_pending", 64'(pending), 64'd2);
    ack_rsp(32'h1357_9BDF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1357_9BDF);
    tick();
    ack_rsp(32'h2468_ACE0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2468_ACE0);
    tick();
    check("drain_pending", 64'(pending), 64'd0);
    check("drain_full",    64'(full),    64'd0);
    check("err_sticky",    64'(err),     64'd1);

    // Reset with records pending, then an ack into the empty queue
    do_reset();
    check("rst2_err", 64'(err), 64'd0);
    load_req(SZ_WORD, 3'd0, 1'b0);
    tick();
    load_req(SZ_WORD, 3'd0, 1'b0);
    tick();
    rst = 1'b1;
    ack = 1'b1;
    tick();
    check("midrst_pending", 64'(pending), 64'd0);
    check("midrst_err",     64'(err),     64'd0);
    rst = 1'b0;
    ack = 1'b1;
    tick();
    check("ack_empty_err",     64'(err),     64'd1);
    check("ack_empty_pending", 64'(pending), 64'd0);

    // Flush: two loads killed, store pushed afterwards survives
    do_reset();
    load_req(SZ_WORD, 3'd0, 1'b0);
    tick();
    load_req(SZ_WORD, 3'd0, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    check("flush_pending", 64'(pending), 64'd2);
    store_req(SZ_WORD, 3'd0);
    ack_rsp(32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    ack_rsp(32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    ack_rsp(32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("flush_drain", 64'(pending), 64'd0);
    check("flush_err",   64'(err),     64'd0);

    // Request pushed in the flush cycle is not killed
    load_req(SZ_WORD, 3'd0, 1'b0);
    tick();
    flush = 1'b1;
    load_req(SZ_BYTE, 3'd2, 1'b0);
    tick();
    ack_rsp(32'h4444_4444, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    ack_rsp(32'h0055_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0055);
    tick();
    tick();
    check("flush2_pending", 64'(pending), 64'd0);

    // XLEN=64 lanes
    single64("lwu64", SZ_WORD,  3'd4, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF);
    single64("lw64",  SZ_WORD,  3'd4, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    single64("ld64",  SZ_DWORD, 3'd0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    single64("ldbe64",SZ_DWORD, 3'd0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hEFCD_AB89_6745_2301);
    single64("lb64",  SZ_BYTE,  3'd7, 1'b0, 1'b0, 64'h9000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF90);
    check("err64", 64'(err64), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
